csla_word_sequencer: RTL and testbench
======================================

Name: csla_word_sequencer

Overview:
Multi-cycle wide adder controller. It time-shares one SLICE_W-bit carry-select slice across a DATA_W-bit addition, one slice per cycle, least significant slice first.
The slice contains a ripple adder with carry-in 0 and a binary-to-excess-1 converter (BEC) that produces the +1 result; the saved inter-slice carry selects between the two.
Sits between the operand source and the result consumer, with a valid/ready handshake on both sides.

Parameters:
DATA_W, 32, total operand width; must be a multiple of SLICE_W (elaboration-time check).
SLICE_W, 8, width of the shared add/BEC slice.
NUM_SLICES, DATA_W/SLICE_W, derived; not overridable.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_cin  input  1  carry-in to slice 0
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_sum  output  DATA_W  sum
out_cout  output  1  carry-out of the top slice
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; out_sum=0, out_cout=0, out_valid=0, busy=0; slice index=0; carry register=0.
- Reset mid-operation aborts the addition; no partial result is ever presented.
- FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b, in_cin (into the carry register).
  - Clear index and out_sum, then go to RUN.
- RUN: in_ready=0. Each cycle, for slice k=index:
  - raw = a[k] + b[k], zero-extended to SLICE_W+1 bits.
  - inc = BEC(raw).
  - sel = carry ? inc : raw.
  - out_sum slice k <= sel[SLICE_W-1:0]; carry <= sel[SLICE_W].
  - If index==NUM_SLICES-1, go to DONE and set out_cout <= sel[SLICE_W]; otherwise index++.
- DONE: out_valid=1. out_sum and out_cout are held stable while out_ready=0. On out_ready=1, go to IDLE.
- out_valid is combinational from state only and has no dependence on out_ready.
- Latency: acceptance edge at cycle t; out_valid=1 in cycle t+NUM_SLICES+1 (cycle t+5 for default parameters).
- Throughput: one result per NUM_SLICES+2 cycles with no back-pressure. in_ready is low for the whole of RUN and DONE, so there is no accept on the out_ready cycle.
- in_a and in_b changing after acceptance have no effect.
- All arithmetic is unsigned modulo 2^DATA_W; the carry goes to out_cout.
- Wrap case: an all-ones slice with carry=1 gives a slice sum of 0 and carry 1. The BEC's top bit is the carry.

Optional Feature:
Macro CSLA_SEQ_OVF_EN.
- Defined: adds output port out_ovf (1 bit).
  - out_ovf = two's-complement signed overflow of the full DATA_W add (MSBs of a and b equal, and sum MSB differs).
  - Registered with out_cout, valid only with out_valid, reset value 0.
- Not defined: port absent and no overflow logic; all other behaviour identical.

Decomposition:
- Package csla_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default SLICE_W constant;
  - index-width function clog2(NUM_SLICES), minimum 1.
- One combinational sub-module, csla_bec_slice, parameterised on SLICE_W:
  - inputs: a, b, cin;
  - outputs: sum[SLICE_W-1:0], cout;
  - contains the ripple add and the generic (SLICE_W+1)-bit BEC mux.
- The FSM, index counter and registers stay in the top.

Test Plan:
1. in_a=0xFFFFFFFF, in_b=0x00000001, cin=0, out_ready=1 -> out_sum=0x00000000, out_cout=1, out_valid exactly 5 cycles after acceptance, high for one cycle.
2. in_a=0, in_b=0, cin=1 -> out_sum=0x00000001, out_cout=0. Then in_a=0x12345678, in_b=0x0FEDCBA8, cin=0 -> out_sum=0x22222220, out_cout=0.
3. Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_sum stable, in_ready=0 throughout. Raising out_ready gives IDLE next cycle and in_ready=1.
4. in_valid held high with two operand sets -> second accepted only after the first handshake completes. Both results are correct and in order; no operand is lost or duplicated.
5. rst_n pulsed low during RUN (index=2) -> out_valid=0, out_sum=0 and busy=0 immediately. A new add after release gives a correct result.
6. CSLA_SEQ_OVF_EN defined: 0x7FFFFFFF+0x00000001 -> out_ovf=1, out_cout=0. 0xFFFFFFFF+0xFFFFFFFF -> out_ovf=0, out_cout=1, out_sum=0xFFFFFFFE.

Source files
------------

// File: rtl/csla_word_sequencer_pkg.sv
// csla_pkg: shared types and constants for the carry-select word sequencer.
// Provides the FSM state encoding, the default slice width and the
// index-width helper used to size the slice counter.
package csla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csla_state_e;

    localparam int CSLA_SLICE_W = 8;

    // Width of a counter that walks num_slices slices; never narrower than 1 bit.
    function automatic int csla_idx_w(input int num_slices);
        int w;
        w = $clog2(num_slices);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/csla_word_sequencer_bec_slice.sv
// csla_bec_slice: one carry-select slice. A ripple adder with carry-in 0
// produces the raw sum; a binary-to-excess-1 converter produces raw+1; cin
// picks between them. The BEC output top bit is the slice carry-out.
module csla_bec_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] raw_s;
    logic [SLICE_W:0] inc_s;
    logic [SLICE_W:0] sel_s;

    // Ripple-carry add of a and b with carry-in 0, zero-extended by the final carry.
    always_comb begin : ripple_add
        logic c;
        c     = 1'b0;
        raw_s = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            raw_s[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        raw_s[SLICE_W] = c;
    end

    // Excess-1 conversion: each bit flips when every lower raw bit is one.
    always_comb begin : bec
        logic t;
        t     = 1'b1;
        inc_s = '0;
        for (int i = 0; i <= SLICE_W; i++) begin
            inc_s[i] = raw_s[i] ^ t;
            t        = t & raw_s[i];
        end
    end

    // Carry-select mux between the +0 and +1 results.
    always_comb begin : carry_select
        sel_s = cin ? inc_s : raw_s;
        sum   = sel_s[SLICE_W-1:0];
        cout  = sel_s[SLICE_W];
    end

endmodule

// File: rtl/csla_word_sequencer.sv
// csla_word_sequencer: DATA_W-bit adder built by time-sharing one SLICE_W-bit
// carry-select slice, least significant slice first, with valid/ready on both
// sides. Optional macro CSLA_SEQ_OVF_EN adds the out_ovf signed-overflow output.
module csla_word_sequencer
    import csla_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = CSLA_SLICE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              busy
`ifdef CSLA_SEQ_OVF_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int IDX_W      = csla_idx_w(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    if ((DATA_W % SLICE_W) != 0) begin : g_width_check
        $error("csla_word_sequencer: DATA_W must be a multiple of SLICE_W");
    end

    csla_state_e                           state_r;
    logic [IDX_W-1:0]                      idx_r;
    logic                                  carry_r;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]    a_r;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]    b_r;
    logic [NUM_SLICES-1:0][SLICE_W-1:0]    sum_r;
    logic                                  cout_r;
    logic [SLICE_W-1:0]                    slice_sum_s;
    logic                                  slice_cout_s;
`ifdef CSLA_SEQ_OVF_EN
    logic                                  ovf_r;
    logic                                  msb_a_s;
    logic                                  msb_b_s;
`endif

    csla_bec_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .a    (a_r[idx_r]),
        .b    (b_r[idx_r]),
        .cin  (carry_r),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r == RUN) || (state_r == DONE);
    assign out_sum   = sum_r;
    assign out_cout  = cout_r;
`ifdef CSLA_SEQ_OVF_EN
    assign out_ovf   = ovf_r;
    assign msb_a_s   = a_r[NUM_SLICES-1][SLICE_W-1];
    assign msb_b_s   = b_r[NUM_SLICES-1][SLICE_W-1];
`endif

    // Sequencer FSM: latch operands, walk the slices carrying between them, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
`ifdef CSLA_SEQ_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        carry_r <= in_cin;
                        idx_r   <= '0;
                        sum_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[idx_r] <= slice_sum_s;
                    carry_r      <= slice_cout_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r  <= slice_cout_s;
`ifdef CSLA_SEQ_OVF_EN
                        ovf_r   <= (msb_a_s == msb_b_s) && (slice_sum_s[SLICE_W-1] != msb_a_s);
`endif
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csla_word_sequencer.sv
// Scoreboard bench for csla_word_sequencer: accepted operands push a
// reference result (plain wide arithmetic) into a queue; an independent
// monitor pops and compares on every output handshake.
module tb_csla_word_sequencer;

    localparam int DATA_W     = 32;
    localparam int SLICE_W    = 8;
    localparam int NUM_SLICES = DATA_W / SLICE_W;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              cout;
        logic              ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic              in_cin = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_sum;
    logic              out_cout;
    logic              busy;
    logic              ovf_s;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   rdy_rand = 1'b0;
    bit   prev_valid = 1'b0;
    bit   hs_pending = 1'b0;

    csla_word_sequencer #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef CSLA_SEQ_OVF_EN
        ,
        .out_ovf   (ovf_s)
`endif
    );

`ifndef CSLA_SEQ_OVF_EN
    assign ovf_s = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Reference: unsigned wide add, carry out of the top, signed overflow from the MSBs.
    function automatic exp_t ref_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
        exp_t e;
        logic [DATA_W:0] t;
        t      = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        e.sum  = t[DATA_W-1:0];
        e.cout = t[DATA_W];
        e.ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (e.sum[DATA_W-1] != a[DATA_W-1]);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present one operand set and hold it until the DUT takes it.
    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic cin);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 33'd0, 33'd1);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", 33'(exp_q.size()), 33'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: records acceptances, checks every presented result against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                hs_pending = 1'b0;
            end else begin
                chk("ready_vs_busy", 33'(in_ready), 33'(!busy));
                if (hs_pending) begin
                    chk("valid_one_cycle", 33'(out_valid), 33'd0);
                    chk("ready_after_take", 33'(in_ready), 33'd1);
                    hs_pending = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_add(in_a, in_b, in_cin));
                    acc_q.push_back(cyc);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_valid", 33'd1, 33'd0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_valid) chk("latency", 33'(cyc - acc_q[0]), 33'(NUM_SLICES + 1));
                        chk("sum", {1'b0, out_sum}, {1'b0, e.sum});
                        chk("cout", 33'(out_cout), 33'(e.cout));
`ifdef CSLA_SEQ_OVF_EN
                        chk("ovf", 33'(ovf_s), 33'(e.ovf));
`endif
                        chk("busy_done", 33'(busy), 33'd1);
                        chk("ready_done", 33'(in_ready), 33'd0);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                            hs_pending = 1'b1;
                        end
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 33'(out_valid), 33'd0);
        chk("rst_sum", {1'b0, out_sum}, 33'd0);
        chk("rst_cout", 33'(out_cout), 33'd0);
        chk("rst_busy", 33'(busy), 33'd0);
        chk("rst_ready", 33'(in_ready), 33'd1);
        chk("rst_ovf", 33'(ovf_s), 33'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Directed: full carry ripple, carry-in only, mixed slices (back to back keeps in_valid high)
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b1);
        send(32'h1234_5678, 32'h0FED_CBA8, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        drain();

        // Back-pressure: result must hold for 10 cycles
        out_ready = 1'b0;
        send(32'h89AB_CDEF, 32'h7654_3210, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_valid_seen", 33'(out_valid), 33'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_still_valid", 33'(out_valid), 33'd1);
        out_ready = 1'b1;
        drain();

        // Reset in the middle of RUN with partially written sum
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        chk("abort_valid", 33'(out_valid), 33'd0);
        chk("abort_sum", {1'b0, out_sum}, 33'd0);
        chk("abort_busy", 33'(busy), 33'd0);
        chk("abort_cout", 33'(out_cout), 33'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0F0F_00FF, 32'h00F1_FF01, 1'b0);
        drain();

        // Randomised traffic with random back-pressure and idle gaps
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = '1;
                1: rb = ~ra;
                2: rb[7:0] = 8'hFF;
                default: ra = ra;
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_rand  = 1'b0;
        #2;
        out_ready = 1'b1;
        drain();
        repeat (2) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
